// File: rtl/duck_game_ctrl.sv
// Duck Hunt round sequencer: gun movement, duck launch, shot scheduling,
// ammo and fly-timeout tracking, per-duck hit bitmap on the LEDs.
module duck_game_ctrl #(
  parameter int SCREEN_W      = 640,
  parameter int GUN_W         = 32,
  parameter int STEP          = 4,
  parameter int SHOTS         = 3,
  parameter int FLY_FRAMES    = 240,
  parameter int RESULT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       izq,
  input  logic       der,
  input  logic       fire,
  input  logic       frame_tick,
  input  logic       duck_hit,
  input  logic       bullet_done,
  output logic [9:0] gun_x,
  output logic       shot_start,
  output logic       duck_launch,
  output logic       duck_active,
  output logic [7:0] led
);

  typedef enum logic [2:0] {IDLE, LAUNCH, FLY, SHOT, RESULT, DONE} state_t;

  localparam logic [9:0] GUN_MAX  = 10'(SCREEN_W - GUN_W);
  localparam logic [9:0] GUN_HOME = 10'((SCREEN_W - GUN_W) / 2);
  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam int FW = $clog2(FLY_FRAMES);
  localparam int RW = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;

  state_t          state, next_state;
  logic            fire_q, fire_edge;
  logic [FW-1:0]   fly_cnt;
  logic            fly_expired, fly_last;
  logic [2:0]      shots;
  logic            hit_flag;
  logic [2:0]      duck_idx;
  logic [RW-1:0]   res_cnt;
  logic            res_last;
  logic            launch_d, shot_d, active_d;

  assign fire_edge = fire & ~fire_q;
  // fly_cnt parks at FLY_FRAMES-1 once the timer expires; fly_expired remembers it
  assign fly_last  = frame_tick && !fly_expired && (fly_cnt == FW'(FLY_FRAMES - 1));
  assign res_last  = frame_tick && (res_cnt == RW'(RESULT_FRAMES - 1));

  // State register plus registered (glitch-free, reset-clean) output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      duck_launch <= 1'b0;
      shot_start  <= 1'b0;
      duck_active <= 1'b0;
    end else begin
      state       <= next_state;
      duck_launch <= launch_d;
      shot_start  <= shot_d;
      duck_active <= active_d;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (fire_edge) next_state = LAUNCH;
      LAUNCH: next_state = FLY;
      FLY: begin
        if (fly_last)                           next_state = RESULT;
        else if (fire_edge && (shots != 3'd0))  next_state = SHOT;
      end
      SHOT: begin
        if (duck_hit) next_state = RESULT;
        else if (bullet_done)
          next_state = (fly_expired || fly_last || (shots == 3'd0)) ? RESULT : FLY;
      end
      RESULT: if (res_last) next_state = (duck_idx == 3'd7) ? DONE : LAUNCH;
      DONE:   if (fire_edge) next_state = LAUNCH;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state; registered in the state process
  always_comb begin
    launch_d = (next_state == LAUNCH);
    shot_d   = (state == FLY) && (next_state == SHOT);
    active_d = (next_state == FLY) || (next_state == SHOT);
  end

  // Datapath: fire edge, gun position, ammo, timers, hit bitmap
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q      <= 1'b1;
      gun_x       <= GUN_HOME;
      fly_cnt     <= '0;
      fly_expired <= 1'b0;
      shots       <= '0;
      hit_flag    <= 1'b0;
      duck_idx    <= '0;
      res_cnt     <= '0;
      led         <= '0;
    end else begin
      fire_q <= fire;

      if (frame_tick) begin
        if (izq && !der)
          gun_x <= (gun_x < STEP_V) ? 10'd0 : gun_x - STEP_V;
        else if (der && !izq)
          gun_x <= (gun_x > GUN_MAX - STEP_V) ? GUN_MAX : gun_x + STEP_V;
      end

      if (state == LAUNCH) begin
        shots       <= 3'(SHOTS);
        fly_cnt     <= '0;
        fly_expired <= 1'b0;
        hit_flag    <= 1'b0;
      end

      if ((state == FLY || state == SHOT) && frame_tick && !fly_expired) begin
        if (fly_last) fly_expired <= 1'b1;
        else          fly_cnt     <= fly_cnt + 1'b1;
      end

      if (shot_d) shots <= shots - 3'd1;

      if (state == SHOT && duck_hit) hit_flag <= 1'b1;

      // Hit recorded on entry; includes a hit arriving in the same cycle
      if (next_state == RESULT && state != RESULT) begin
        led[duck_idx] <= hit_flag | ((state == SHOT) && duck_hit);
        res_cnt       <= '0;
      end

      if (state == RESULT && frame_tick) begin
        res_cnt <= res_cnt + 1'b1;
        if (res_last && duck_idx != 3'd7) duck_idx <= duck_idx + 3'd1;
      end

      if (state == DONE && fire_edge) begin
        led      <= '0;
        duck_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_duck_game_ctrl.sv
// Directed bench for duck_game_ctrl (FLY_FRAMES=4, RESULT_FRAMES=2, SHOTS=3).
module tb_duck_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, izq, der, fire, frame_tick, duck_hit, bullet_done;
  logic [9:0] gun_x;
  logic       shot_start, duck_launch, duck_active;
  logic [7:0] led;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #10 clk = ~clk;

  duck_game_ctrl #(
    .SCREEN_W(640), .GUN_W(32), .STEP(4), .SHOTS(3),
    .FLY_FRAMES(4), .RESULT_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .izq(izq), .der(der), .fire(fire),
    .frame_tick(frame_tick), .duck_hit(duck_hit), .bullet_done(bullet_done),
    .gun_x(gun_x), .shot_start(shot_start), .duck_launch(duck_launch),
    .duck_active(duck_active), .led(led)
  );

  typedef struct {
    logic       rst, l, r, f, tk, hit, bd;
    logic [9:0] gun;
    logic       shot, launch, active;
    logic [7:0] ledv;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic rst, logic l, logic r, logic f, logic tk,
                              logic hit, logic bd, logic [9:0] gun, logic shot,
                              logic launch, logic active, logic [7:0] ledv);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.f = f; v.tk = tk; v.hit = hit; v.bd = bd;
    v.gun = gun; v.shot = shot; v.launch = launch; v.active = active; v.ledv = ledv;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // Release then press fire: the edge is taken at the second clock
  task automatic press();
    fire = 1'b0;
    cyc();
    fire = 1'b1;
    cyc();
  endtask

  // Hold RESULT for two ticks, then expect a launch pulse (or DONE)
  task automatic finish_result(input string name, input logic exp_launch);
    tick();
    check({name, "_held"}, duck_active, 0);
    tick();
    check({name, "_launch"}, duck_launch, exp_launch);
  endtask

  task automatic hit_duck(input string name, input logic [7:0] exp_led);
    cyc();
    press();
    check({name, "_shot"}, shot_start, 1);
    duck_hit = 1'b1;
    cyc();
    duck_hit = 1'b0;
    check({name, "_led"}, led, exp_led);
  endtask

  task automatic escape_duck(input string name, input logic [7:0] exp_led);
    cyc();
    fire = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check({name, "_flying"}, duck_active, 1);
    tick();
    check({name, "_escaped"}, duck_active, 0);
    check({name, "_led"}, led, exp_led);
  endtask

  initial begin
    reset = 0; izq = 0; der = 0; fire = 0; frame_tick = 0; duck_hit = 0; bullet_done = 0;

    //                rst l  r  f  tk hit bd  gun   shot lau act led
    vecs[0]  = mk(1, 0, 0, 1, 0, 0, 0, 10'd304, 0, 0, 0, 8'h00); // reset, fire held
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0, 10'd304, 0, 0, 0, 8'h00); // held fire: no edge
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd304, 0, 0, 0, 8'h00);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 10'd304, 0, 1, 0, 8'h00); // launch
    vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, 10'd304, 0, 0, 1, 8'h00); // FLY
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd304, 0, 0, 1, 8'h00);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0, 10'd304, 1, 0, 1, 8'h00); // shot_start
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 10'd304, 0, 0, 1, 8'h00); // SHOT
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 10'd304, 0, 0, 0, 8'h01); // hit
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 10'd304, 0, 0, 0, 8'h01);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 10'd304, 0, 0, 0, 8'h01);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 10'd304, 0, 1, 0, 8'h01); // next duck
    vecs[12] = mk(0, 1, 0, 0, 1, 0, 0, 10'd300, 0, 0, 1, 8'h01); // left step
    vecs[13] = mk(0, 0, 1, 0, 1, 0, 0, 10'd304, 0, 0, 1, 8'h01); // right step
    vecs[14] = mk(0, 1, 1, 0, 1, 0, 0, 10'd304, 0, 0, 1, 8'h01); // both: hold

    for (int i = 0; i < 15; i++) begin
      reset = vecs[i].rst; izq = vecs[i].l; der = vecs[i].r; fire = vecs[i].f;
      frame_tick = vecs[i].tk; duck_hit = vecs[i].hit; bullet_done = vecs[i].bd;
      cyc();
      check($sformatf("vec%0d_gun", i),    gun_x,       vecs[i].gun);
      check($sformatf("vec%0d_shot", i),   shot_start,  vecs[i].shot);
      check($sformatf("vec%0d_launch", i), duck_launch, vecs[i].launch);
      check($sformatf("vec%0d_active", i), duck_active, vecs[i].active);
      check($sformatf("vec%0d_led", i),    led,         vecs[i].ledv);
    end
    izq = 0; der = 0; frame_tick = 0;

    // Duck 1: three shots all missing; ammo runs out -> miss
    for (int k = 0; k < 3; k++) begin
      press();
      check($sformatf("ammo_shot%0d", k), shot_start, 1);
      bullet_done = 1'b1;
      cyc();
      bullet_done = 1'b0;
      check($sformatf("ammo_after%0d", k), duck_active, (k < 2) ? 1 : 0);
    end
    check("ammo_led", led, 8'h01);
    press();
    check("ammo_4th_noshot", shot_start, 0);
    cyc();
    check("ammo_4th_noshot2", shot_start, 0);
    finish_result("d1", 1'b1);

    // Duck 2: hit and bullet_done together counts as a hit
    cyc();
    press();
    check("both_shot", shot_start, 1);
    duck_hit = 1'b1; bullet_done = 1'b1;
    cyc();
    duck_hit = 1'b0; bullet_done = 1'b0;
    check("both_active", duck_active, 0);
    check("both_led", led, 8'h05);
    finish_result("d2", 1'b1);

    // Duck 3: fly timer expires while a bullet is in flight
    cyc();
    press();
    check("tos_shot", shot_start, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tos_stay%0d", i), duck_active, 1);
    end
    bullet_done = 1'b1;
    cyc();
    bullet_done = 1'b0;
    check("tos_leave", duck_active, 0);
    check("tos_led", led, 8'h05);
    finish_result("d3", 1'b1);

    // Duck 4: hit
    hit_duck("d4", 8'h15);
    finish_result("d4", 1'b1);

    // Duck 5: fire edge coincides with the timeout tick; timeout wins
    cyc();
    fire = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    fire = 1'b1; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("tie_active", duck_active, 0);
    check("tie_shot", shot_start, 0);
    cyc();
    check("tie_shot2", shot_start, 0);
    check("tie_led", led, 8'h15);
    finish_result("d5", 1'b1);

    // Duck 6: hit; duck 7: escape -> DONE
    hit_duck("d6", 8'h55);
    finish_result("d6", 1'b1);
    escape_duck("d7", 8'h55);
    finish_result("d7", 1'b0);
    cyc();
    check("done_led", led, 8'h55);
    check("done_launch", duck_launch, 0);

    press();
    check("restart_led", led, 8'h00);
    check("restart_launch", duck_launch, 1);
    cyc();
    check("restart_active", duck_active, 1);
    izq = 1'b1;
    tick();
    izq = 1'b0;
    check("restart_gun", gun_x, 300);

    // Reset mid-FLY with fire held
    reset = 1'b1; fire = 1'b1;
    cyc();
    check("rst_gun", gun_x, 304);
    check("rst_active", duck_active, 0);
    check("rst_launch", duck_launch, 0);
    check("rst_shot", shot_start, 0);
    check("rst_led", led, 0);
    reset = 1'b0;
    cyc();
    check("rst_noedge", duck_launch, 0);

    // Gun saturation in IDLE
    izq = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    check("gun_min", gun_x, 0);
    izq = 1'b0; der = 1'b1;
    for (int i = 0; i < 160; i++) tick();
    check("gun_max", gun_x, 608);
    izq = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("gun_both", gun_x, 608);
    izq = 1'b1; der = 1'b0;
    tick();
    check("gun_back", gun_x, 604);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
